// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one bus request per load/store,
// aligns strobes and load data, stalls until completion and registers the MEM/WB boundary.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic        MEM_Flush,
    input  logic        MEM_ExcptIn,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic        MEM_ReadMem,
    input  logic        MEM_WriteMem,
    input  logic [1:0]  MEM_Size,
    input  logic        MEM_LoadSign,
    input  logic [4:0]  MEM_Dst,
    input  logic        MEM_RegWr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        MEM_AddrErr,
    output logic        MEM_AddrErrIsStore,
    output logic        MEM_Stall,
    output logic        WB_Valid,
    output logic        WB_RegWr,
    output logic [4:0]  WB_Dst,
    output logic [31:0] WB_MemData
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic        drop;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic [1:0]  lat_size;
    logic        lat_wr;
    logic        lat_sign;

    logic        mem_op;
    logic        misalign;
    logic        access;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_data;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        misalign = 1'b0;
        wstrb_c  = 4'b1111;
        wdata_c  = MEM_OutB;
        case (MEM_Size)
            2'b00: begin
                wstrb_c = 4'b0001 << MEM_ALUOut[1:0];
                wdata_c = {4{MEM_OutB[7:0]}};
            end
            2'b01: begin
                misalign = MEM_ALUOut[0];
                wstrb_c  = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{MEM_OutB[15:0]}};
            end
            default: misalign = |MEM_ALUOut[1:0];
        endcase
        if (!MEM_WriteMem)
            wstrb_c = 4'b0000;
    end

    assign mem_op             = MEM_Valid & (MEM_ReadMem | MEM_WriteMem);
    assign MEM_AddrErr        = mem_op & misalign;
    assign MEM_AddrErrIsStore = MEM_AddrErr & MEM_WriteMem;
    assign access             = mem_op & ~MEM_ExcptIn & ~MEM_AddrErr & ~MEM_Flush;

    // Load alignment uses the latched request, since the response arrives in WAIT.
    assign rbyte = data_rdata[{lat_addr[1:0], 3'b000} +: 8];
    assign rhalf = data_rdata[{lat_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (lat_size)
            2'b00:   load_data = {{24{lat_sign & rbyte[7]}}, rbyte};
            2'b01:   load_data = {{16{lat_sign & rhalf[15]}}, rhalf};
            default: load_data = data_rdata;
        endcase
    end

    always_comb begin
        if (state == IDLE) begin
            data_req   = access;
            data_wr    = MEM_WriteMem;
            data_size  = MEM_Size;
            data_addr  = MEM_ALUOut;
            data_wstrb = wstrb_c;
            data_wdata = wdata_c;
        end else begin
            data_req   = (state == REQ);
            data_wr    = lat_wr;
            data_size  = lat_size;
            data_addr  = lat_addr;
            data_wstrb = lat_wstrb;
            data_wdata = lat_wdata;
        end
    end

    assign MEM_Stall = ((state == IDLE) & access) | (state == REQ) |
                       ((state == WAIT) & ~data_data_ok);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drop      <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_size  <= '0;
            lat_wr    <= 1'b0;
            lat_sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        lat_addr  <= MEM_ALUOut;
                        lat_wdata <= wdata_c;
                        lat_wstrb <= wstrb_c;
                        lat_size  <= MEM_Size;
                        lat_wr    <= MEM_WriteMem;
                        lat_sign  <= MEM_LoadSign;
                        state     <= data_addr_ok ? WAIT : REQ;
                    end
                end
                REQ: begin
                    // A request once raised stays up; a flush only marks its response for discard.
                    if (data_addr_ok)
                        state <= WAIT;
                    if (MEM_Flush)
                        drop <= 1'b1;
                end
                WAIT: begin
                    if (data_data_ok) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (MEM_Flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_Valid   <= 1'b0;
            WB_RegWr   <= 1'b0;
            WB_Dst     <= '0;
            WB_MemData <= '0;
        end else if (!MEM_Stall) begin
            WB_Valid   <= MEM_Valid & ~MEM_Flush & ~drop;
            WB_RegWr   <= MEM_Valid & MEM_RegWr & ~MEM_Flush & ~MEM_ExcptIn & ~MEM_AddrErr & ~drop;
            WB_Dst     <= MEM_Dst;
            WB_MemData <= ((state == WAIT) && !lat_wr) ? load_data : MEM_ALUOut;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a small bus responder plus a scoreboard of
// expected MEM/WB results checked the cycle after each access retires.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Valid, MEM_Flush, MEM_ExcptIn;
    logic [31:0] MEM_ALUOut, MEM_OutB;
    logic        MEM_ReadMem, MEM_WriteMem;
    logic [1:0]  MEM_Size;
    logic        MEM_LoadSign;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegWr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        MEM_AddrErr, MEM_AddrErrIsStore, MEM_Stall;
    logic        WB_Valid, WB_RegWr;
    logic [4:0]  WB_Dst;
    logic [31:0] WB_MemData;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .MEM_Valid(MEM_Valid), .MEM_Flush(MEM_Flush), .MEM_ExcptIn(MEM_ExcptIn),
        .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB),
        .MEM_ReadMem(MEM_ReadMem), .MEM_WriteMem(MEM_WriteMem),
        .MEM_Size(MEM_Size), .MEM_LoadSign(MEM_LoadSign),
        .MEM_Dst(MEM_Dst), .MEM_RegWr(MEM_RegWr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .MEM_AddrErr(MEM_AddrErr), .MEM_AddrErrIsStore(MEM_AddrErrIsStore),
        .MEM_Stall(MEM_Stall),
        .WB_Valid(WB_Valid), .WB_RegWr(WB_RegWr), .WB_Dst(WB_Dst), .WB_MemData(WB_MemData)
    );

    always #5 clk = ~clk;

    // Bus responder: addr_ok after hold_cycles of pending request, data_ok resp_lat cycles later.
    int          hold_cycles = 0;
    int          resp_lat    = 1;
    int          wait_cnt    = 0;
    int          resp_cnt    = 0;
    logic [31:0] bus_rdata   = '0;

    assign data_addr_ok = data_req && (wait_cnt >= hold_cycles);
    assign data_data_ok = (resp_cnt == 1);
    assign data_rdata   = bus_rdata;

    always @(posedge clk) begin
        if (data_req && data_addr_ok) begin
            wait_cnt <= 0;
            resp_cnt <= resp_lat;
        end else begin
            if (data_req)
                wait_cnt <= wait_cnt + 1;
            if (resp_cnt != 0)
                resp_cnt <= resp_cnt - 1;
        end
    end

    typedef struct {
        logic        regwr;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t     sb[$];
    int          total = 0;
    int          bad   = 0;
    int          stalls;
    int          n;
    logic        s_req, s_wr, s_err;
    logic [3:0]  s_strb;
    logic [31:0] s_wdata, s_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        MEM_Valid    = 1'b0;
        MEM_ReadMem  = 1'b0;
        MEM_WriteMem = 1'b0;
        MEM_ExcptIn  = 1'b0;
        MEM_Flush    = 1'b0;
        MEM_RegWr    = 1'b0;
    endtask

    // Called just after a falling edge; returns in the last cycle before the WB-loading edge.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] dst, input logic regwr, input logic excpt,
                         input logic perturb, output int nstall);
        logic [31:0] a0, d0;
        MEM_Valid    = 1'b1;
        MEM_ReadMem  = rd;
        MEM_WriteMem = wr;
        MEM_Size     = size;
        MEM_LoadSign = sign;
        MEM_ALUOut   = addr;
        MEM_OutB     = wdata;
        MEM_Dst      = dst;
        MEM_RegWr    = regwr;
        MEM_ExcptIn  = excpt;
        nstall = 0;
        #2;
        s_req = data_req; s_wr = data_wr; s_err = MEM_AddrErr;
        s_strb = data_wstrb; s_wdata = data_wdata; s_addr = data_addr;
        a0 = data_addr;
        d0 = data_wdata;
        while (MEM_Stall) begin
            nstall++;
            if (nstall > 40) begin
                $display("FAIL stall_bound observed=%0d expected<=40", nstall);
                $fatal(1, "stall never released");
            end
            @(negedge clk);
            if (perturb)
                MEM_OutB = ~wdata;
            #2;
            if (data_req) begin
                check("req_addr_hold", data_addr, a0);
                check("req_wdata_hold", data_wdata, d0);
            end
        end
    endtask

    task automatic finish_wb();
        wb_exp_t e;
        @(negedge clk);
        bubble();
        #2;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty observed=0 expected>0");
        end else begin
            e = sb.pop_front();
            check("wb_valid", 32'(WB_Valid), 32'd1);
            check("wb_regwr", 32'(WB_RegWr), 32'(e.regwr));
            check("wb_dst", 32'(WB_Dst), 32'(e.dst));
            if (e.chk_data)
                check("wb_data", WB_MemData, e.data);
        end
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        MEM_ALUOut = '0; MEM_OutB = '0; MEM_Size = 2'b10; MEM_LoadSign = 1'b0; MEM_Dst = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_wb_valid", 32'(WB_Valid), 32'd0);
        check("rst_wb_regwr", 32'(WB_RegWr), 32'd0);
        check("rst_wb_data", WB_MemData, 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_stall", 32'(MEM_Stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // lw 0x100 on a zero-wait bus
        bus_rdata = 32'hDEADBEEF;
        sb.push_back('{regwr: 1'b1, dst: 5'd5, data: 32'hDEADBEEF, chk_data: 1'b1});
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, stalls);
        check("lw_req", 32'(s_req), 32'd1);
        check("lw_addr", s_addr, 32'h100);
        check("lw_stalls", 32'(stalls), 32'd1);
        finish_wb();

        // lb / lbu 0x103
        bus_rdata = 32'h80FF_0000;
        sb.push_back('{regwr: 1'b1, dst: 5'd6, data: 32'hFFFFFF80, chk_data: 1'b1});
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, stalls);
        finish_wb();
        sb.push_back('{regwr: 1'b1, dst: 5'd6, data: 32'h00000080, chk_data: 1'b1});
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, stalls);
        finish_wb();

        // lh 0x102 signed
        sb.push_back('{regwr: 1'b1, dst: 5'd8, data: 32'hFFFF80FF, chk_data: 1'b1});
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, stalls);
        finish_wb();

        // sh 0x202
        sb.push_back('{regwr: 1'b0, dst: 5'd0, data: 32'h202, chk_data: 1'b1});
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 1'b0, stalls);
        check("sh_wr", 32'(s_wr), 32'd1);
        check("sh_strb", 32'(s_strb), 32'b1100);
        check("sh_wdata", s_wdata, 32'hABCDABCD);
        finish_wb();

        // sb 0x201
        sb.push_back('{regwr: 1'b0, dst: 5'd0, data: 32'h201, chk_data: 1'b1});
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000005A, 5'd0, 1'b0, 1'b0, 1'b0, stalls);
        check("sb_strb", 32'(s_strb), 32'b0010);
        check("sb_wdata", s_wdata, 32'h5A5A5A5A);
        finish_wb();

        // lw 0x101 misaligned: no request, no stall
        sb.push_back('{regwr: 1'b0, dst: 5'd3, data: 32'h0, chk_data: 1'b0});
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, stalls);
        check("ae_err", 32'(s_err), 32'd1);
        check("ae_req", 32'(s_req), 32'd0);
        check("ae_stalls", 32'(stalls), 32'd0);
        finish_wb();

        // load already carrying an exception: suppressed
        sb.push_back('{regwr: 1'b0, dst: 5'd9, data: 32'h0, chk_data: 1'b0});
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, stalls);
        check("exc_req", 32'(s_req), 32'd0);
        check("exc_stalls", 32'(stalls), 32'd0);
        finish_wb();

        // sw with addr_ok withheld 3 cycles, store data perturbed while stalled
        hold_cycles = 3;
        sb.push_back('{regwr: 1'b0, dst: 5'd0, data: 32'h300, chk_data: 1'b1});
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, stalls);
        check("sw_wdata", s_wdata, 32'hCAFEF00D);
        check("sw_strb", 32'(s_strb), 32'b1111);
        check("sw_stalls", 32'(stalls), 32'd4);
        finish_wb();
        hold_cycles = 0;

        // flush while waiting for a slow response
        resp_lat = 4;
        bus_rdata = 32'h55555555;
        MEM_Valid = 1'b1; MEM_ReadMem = 1'b1; MEM_Size = 2'b10; MEM_LoadSign = 1'b0;
        MEM_ALUOut = 32'h400; MEM_Dst = 5'd7; MEM_RegWr = 1'b1;
        #2;
        check("fl_req", 32'(data_req), 32'd1);
        @(negedge clk);
        MEM_Flush = 1'b1;
        #2;
        check("fl_stall_wait", 32'(MEM_Stall), 32'd1);
        @(negedge clk);
        MEM_Flush = 1'b0;
        #2;
        n = 0;
        while (MEM_Stall && n < 20) begin
            check("fl_no_new_req", 32'(data_req), 32'd0);
            @(negedge clk);
            #2;
            n++;
        end
        check("fl_release", 32'(n), 32'd2);
        @(negedge clk);
        bubble();
        #2;
        check("fl_wb_valid", 32'(WB_Valid), 32'd0);
        check("fl_wb_regwr", 32'(WB_RegWr), 32'd0);

        // the next access after a dropped one completes normally
        resp_lat = 1;
        bus_rdata = 32'h0BADF00D;
        sb.push_back('{regwr: 1'b1, dst: 5'd10, data: 32'h0BADF00D, chk_data: 1'b1});
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, stalls);
        check("post_fl_stalls", 32'(stalls), 32'd1);
        finish_wb();

        // reset during WAIT, then a late response that must be ignored
        resp_lat = 3;
        MEM_Valid = 1'b1; MEM_ReadMem = 1'b1; MEM_Size = 2'b10;
        MEM_ALUOut = 32'h500; MEM_Dst = 5'd11; MEM_RegWr = 1'b1;
        #2;
        check("rw_req", 32'(data_req), 32'd1);
        @(negedge clk);
        #2;
        check("rw_in_wait", 32'(MEM_Stall), 32'd1);
        rst = 1'b1;
        bubble();
        #1;
        check("rw_req_off", 32'(data_req), 32'd0);
        check("rw_stall_off", 32'(MEM_Stall), 32'd0);
        check("rw_wb_valid", 32'(WB_Valid), 32'd0);
        check("rw_wb_dst", 32'(WB_Dst), 32'd0);
        check("rw_wb_data", WB_MemData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp_lat = 1;
        bus_rdata = 32'h11112222;
        sb.push_back('{regwr: 1'b1, dst: 5'd12, data: 32'h11112222, chk_data: 1'b1});
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, stalls);
        check("post_rst_stalls", 32'(stalls), 32'd1);
        finish_wb();

        check("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access controller for the MEM stage. Consumes the MEM-stage pipeline register fields (address, store data, load/store type, destination), issues one request per memory instruction on the data-bus request/response interface, aligns load data and store strobes, stalls the pipeline until the access completes, and registers the result into the MEM/WB boundary.

## Interface
- No parameters; address and data widths are fixed at 32.
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- MEM_Valid  in  1  MEM stage holds a live instruction
- MEM_Flush  in  1  kill the current MEM instruction (exception/ERET)
- MEM_ExcptIn  in  1  instruction already carries an exception; suppresses access
- MEM_ALUOut  in  32  effective address
- MEM_OutB  in  32  raw store data (rt)
- MEM_ReadMem / MEM_WriteMem  in  1/1  load / store (never both)
- MEM_Size  in  2  00 byte, 01 half, 10 word
- MEM_LoadSign  in  1  1 = sign-extend sub-word loads
- MEM_Dst  in  5  destination register; MEM_RegWr  in  1  instruction writes a register
- data_req  out  1  request valid; data_wr  out  1  write request
- data_size  out  2  = MEM_Size; data_addr  out  32  = MEM_ALUOut
- data_wstrb  out  4  byte enables; data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  response (read data or write ack) this cycle
- data_rdata  in  32  raw read word
- MEM_AddrErr  out  1  misaligned access (combinational); MEM_AddrErrIsStore  out  1
- MEM_Stall  out  1  hold EXE/MEM and earlier stages
- WB_Valid  out  1; WB_RegWr  out  1; WB_Dst  out  5; WB_MemData  out  32  (registered)

## Operation
- Access = MEM_Valid & (ReadMem|WriteMem) & !MEM_ExcptIn & !MEM_AddrErr & !MEM_Flush.
- Misalign: half with addr[0]=1, word with addr[1:0]!=0 -> MEM_AddrErr=1, no request issued, no stall.
- Store strobes: byte 0001<<addr[1:0], data {4{b}}; half addr[1]?1100:0011, data {2{h}}; word 1111, data unchanged.
- Load align: byte = rdata[8*off+:8], half = rdata[16*addr[1]+:16]; extend by LoadSign; word unchanged.
- FSM states IDLE, REQ, WAIT:
  - IDLE: data_req = Access. addr_ok -> WAIT; else if Access -> REQ.
  - REQ: data_req=1, addr/size/wr/wstrb/wdata held stable from latched copies; addr_ok -> WAIT.
  - WAIT: data_req=0; data_ok -> IDLE, load data captured.
- Requests are never withdrawn. Flush in REQ/WAIT sets a drop flag; the access completes on the bus, its response is discarded, WB_Valid stays 0 for it; flag clears on the data_ok.
- MEM_Stall = (IDLE & Access) | REQ | (WAIT & !data_ok); while a dropped access is outstanding, stall stays asserted until data_ok so a new request cannot overlap.
- MEM/WB register loads when !MEM_Stall: WB_Valid <= MEM_Valid & !Flush; WB_RegWr <= MEM_RegWr & !Flush & !ExcptIn & !AddrErr; WB_Dst <= MEM_Dst; WB_MemData <= aligned load data (or MEM_ALUOut for non-loads).
- Reset (any time, including mid-access): state IDLE, drop flag 0, all WB_* outputs 0, data_req 0; any bus response in flight after reset is ignored (state IDLE ignores data_ok).

## Timing
- Zero-wait bus (addr_ok same cycle as req, data_ok next cycle): load/store costs 2 cycles, 1 stall cycle.
- addr_ok and data_ok in the same cycle in WAIT-pending: addr_ok accepts, data_ok belongs to previous access only when drop flag set; otherwise the bus never returns data_ok before addr_ok.
- Outputs data_* are combinational in IDLE, registered in REQ.
- WB_* visible the cycle after MEM_Stall deasserts.

## Test plan
- Load word addr 0x100, addr_ok same cycle, data_ok next with 0xDEADBEEF -> 1 stall cycle, WB_MemData=0xDEADBEEF, WB_RegWr=1.
- lb addr 0x103 sign, rdata 0x80FF_0000 -> WB_MemData=0xFFFFFF80; lbu same -> 0x00000080.
- sh addr 0x202, OutB 0x1234ABCD -> data_wstrb=1100, data_wdata=0xABCDABCD, data_wr=1.
- lw addr 0x101 -> MEM_AddrErr=1, data_req never asserted, MEM_Stall=0.
- addr_ok withheld 3 cycles -> REQ holds addr/wdata stable, stall 4+ cycles; Flush during WAIT -> response dropped, WB_Valid=0, next access issues only after data_ok.
- rst asserted in WAIT -> immediately IDLE, WB_* =0; late data_ok ignored.
